btb_2bit: RTL and testbench
===========================

# btb_2bit

Direct-mapped branch target buffer with per-entry 2-bit saturating counters. It is the responder for the fetch stage's prediction request. Each cycle the fetch stage presents its current PC. In the same cycle the block returns a taken/not-taken prediction and the predicted target. The execute stage reports each resolved branch or jump back into the block, which updates the table.

## Interface

Parameters:
- `ENTRIES`, default 32: number of table entries; power of 2, minimum 2.
- `IDX_W`, default $clog2(ENTRIES): index width; derived, not overridden.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset; one clock; reset is asynchronous and active-low.
- `pc_i` in 32: fetch PC to look up.
- `hit_o` out 1: predict taken; fetch selects `predicted_pc_o` when 1.
- `predicted_pc_o` out 32: predicted target.
- `update_i` in 1: one-cycle pulse; a control-transfer instruction resolved this cycle.
- `update_pc_i` in 32: PC of the resolved instruction.
- `update_target_i` in 32: resolved target address.
- `taken_i` in 1: actual outcome; 1 = taken.
- `is_jump_i` in 1: resolved instruction is an unconditional jump (JAL/JALR).

## Operation

- **Address split:** index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. PC[1:0] is ignored.
- **Entry contents:** valid bit, tag (30−IDX_W bits), target (32 bits), counter (2 bits).
- **Counter encoding:** 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- **Lookup (combinational):**
  - `match` = valid[idx] & (tag[idx] == tag(`pc_i`)).
  - `hit_o` = `match` & counter[idx][1].
  - `predicted_pc_o` = target[idx] when `match`, else 32'h0.
- **Update, on the rising edge with `update_i`=1:**
  - **Entry matches `update_pc_i`, `is_jump_i`=1:** counter := 11; target := `update_target_i`.
  - **Entry matches, `taken_i`=1:** counter := min(counter+1, 11); target := `update_target_i`.
  - **Entry matches, `taken_i`=0:** counter := max(counter−1, 00); target unchanged.
  - **No match, `taken_i`=1 or `is_jump_i`=1:** allocate. Set valid := 1, tag := tag(`update_pc_i`), target := `update_target_i`. Set counter := 11 if jump, else 10. This replaces any existing entry at that index (direct-mapped, no victim choice).
  - **No match, not taken, not jump:** table unchanged; not-taken branches never allocate.
- **Jump precedence:** `is_jump_i`=1 implies taken regardless of `taken_i`.
- **`update_i`=0:** `update_pc_i`, `update_target_i`, `taken_i` and `is_jump_i` are ignored.
- **Ownership:** the producer guarantees exactly one `update_i` pulse per resolved instruction. The block does not filter duplicates.

## Timing

- **Lookup latency:** 0 cycles. `hit_o` and `predicted_pc_o` are pure functions of `pc_i` and current table state.
- **Update latency:** an update is visible to lookups from the cycle after the capturing edge.
- **Same-cycle conflict:** a lookup and an update to the same index in the same cycle.
  - The lookup returns the pre-update contents; no bypass.
  - The update commits at the edge.
- **Reset (async assert, sync-deasserted externally):** all valid := 0, counters := 01, tags := 0, targets := 0.
  - `hit_o` = 0 and `predicted_pc_o` = 0 immediately on assertion, for any `pc_i`.
  - An update pending at the edge where reset is asserted is discarded.
- **Counter saturation:** increment at 11 stays 11; decrement at 00 stays 00; no wrap.
- **Idle outputs:** no output is registered, so none holds stale state; outputs track `pc_i` every cycle.

## Test plan

1. **Cold start:** release reset; `pc_i`=0x100 → `hit_o`=0, `predicted_pc_o`=0x0.
2. **Allocate:**
   - Pulse update with pc 0x100, target 0x200, taken=1, jump=0.
   - Next cycle, `pc_i`=0x100 → `hit_o`=1, `predicted_pc_o`=0x200 (counter 10).
   - `pc_i`=0x104 → `hit_o`=0.
3. **Hysteresis and saturation on 0x100:**
   - One not-taken update → counter 01: `hit_o`=0, `predicted_pc_o`=0x200.
   - Three taken updates with target 0x240 → counter 11, `predicted_pc_o`=0x240.
   - One not-taken update → counter 10, `hit_o` still 1.
   - Four not-taken updates → counter 00; a fifth leaves it at 00.
4. **Aliasing (ENTRIES=32):**
   - With 0x100 allocated, `pc_i`=0x180 (same index, different tag) → `hit_o`=0, `predicted_pc_o`=0.
   - Not-taken update at 0x180 → 0x100 entry unchanged.
   - Taken update at 0x180, target 0x300 → 0x180 hits with 0x300; 0x100 now misses.
5. **Jump and same-cycle conflict:**
   - Jump update at 0x400, target 0x800, `taken_i`=0 → next cycle `hit_o`=1, `predicted_pc_o`=0x800.
   - Apply an update at 0x400 and a lookup at 0x400 in the same cycle → the lookup returns the old value and the new value appears the following cycle.
6. **Reset mid-operation:** with several entries hitting, assert `rst_ni`=0 between edges → `hit_o` drops to 0 immediately. After release, all prior PCs miss.

Source files
------------

// File: rtl/btb_2bit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational; resolved branches update one entry per clock.
module btb_2bit #(
   parameter int ENTRIES = 32,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] pc_i,
   output logic        hit_o,
   output logic [31:0] predicted_pc_o,
   input  logic        update_i,
   input  logic [31:0] update_pc_i,
   input  logic [31:0] update_target_i,
   input  logic        taken_i,
   input  logic        is_jump_i
);

   localparam int TAG_W = 30 - IDX_W;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   // Lookup path
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_match;

   assign lk_idx   = pc_i[IDX_W+1:2];
   assign lk_tag   = pc_i[31:IDX_W+2];
   assign lk_match = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   assign hit_o          = lk_match && ctr_q[lk_idx][1];
   assign predicted_pc_o = lk_match ? target_q[lk_idx] : 32'h0;

   // Update path: compute the replacement contents of the addressed entry
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_match;
   logic [1:0]       up_ctr_cur;
   logic             wr_en;
   logic             valid_d;
   logic [TAG_W-1:0] tag_d;
   logic [31:0]      target_d;
   logic [1:0]       ctr_d;

   assign up_idx     = update_pc_i[IDX_W+1:2];
   assign up_tag     = update_pc_i[31:IDX_W+2];
   assign up_match   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_ctr_cur = ctr_q[up_idx];

   always_comb begin
      wr_en    = 1'b0;
      valid_d  = valid_q[up_idx];
      tag_d    = tag_q[up_idx];
      target_d = target_q[up_idx];
      ctr_d    = up_ctr_cur;
      if (update_i) begin
         if (up_match) begin
            wr_en = 1'b1;
            if (is_jump_i) begin
               ctr_d    = CTR_STRONG_T;
               target_d = update_target_i;
            end else if (taken_i) begin
               ctr_d    = (up_ctr_cur == CTR_STRONG_T) ? CTR_STRONG_T : up_ctr_cur + 2'd1;
               target_d = update_target_i;
            end else begin
               ctr_d    = (up_ctr_cur == CTR_STRONG_NT) ? CTR_STRONG_NT : up_ctr_cur - 2'd1;
            end
         end else if (taken_i || is_jump_i) begin
            // Allocation overwrites whatever lives at this index.
            wr_en    = 1'b1;
            valid_d  = 1'b1;
            tag_d    = up_tag;
            target_d = update_target_i;
            ctr_d    = is_jump_i ? CTR_STRONG_T : CTR_WEAK_T;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'h0;
            ctr_q[i]    <= CTR_WEAK_NT;
         end
      end else if (wr_en) begin
         valid_q[up_idx]  <= valid_d;
         tag_q[up_idx]    <= tag_d;
         target_q[up_idx] <= target_d;
         ctr_q[up_idx]    <= ctr_d;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_i[1:0], update_pc_i[1:0], CTR_WEAK_T, CTR_WEAK_NT};

endmodule

// File: tb/tb_btb_2bit.sv
// Randomized scoreboard bench for btb_2bit against a table-of-records model.
module tb_btb_2bit;

   localparam int ENTRIES = 32;
   localparam int IDX_W   = 5;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] pc_i;
   logic        hit_o;
   logic [31:0] predicted_pc_o;
   logic        update_i;
   logic [31:0] update_pc_i;
   logic [31:0] update_target_i;
   logic        taken_i;
   logic        is_jump_i;

   btb_2bit #(.ENTRIES(ENTRIES)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .pc_i            (pc_i),
      .hit_o           (hit_o),
      .predicted_pc_o  (predicted_pc_o),
      .update_i        (update_i),
      .update_pc_i     (update_pc_i),
      .update_target_i (update_target_i),
      .taken_i         (taken_i),
      .is_jump_i       (is_jump_i)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: each slot remembers which PC-tag owns it, where it
   // goes, and how confident we are (0..3, taken when >= 2).
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];

   typedef struct {
      logic [31:0] pc;
      logic        hit;
      logic [31:0] tgt;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   bit   chk_req = 0;
   int   errors  = 0;
   int   checks  = 0;

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
         m_ctr[i]   = 1;
      end
   endfunction

   function automatic int slot_of(input int unsigned pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic void model_lookup(input int unsigned pc, output logic hit, output logic [31:0] tgt);
      int s;
      bit owns;
      s    = slot_of(pc);
      owns = m_valid[s] && (m_tag[s] == tag_of(pc));
      hit  = owns && (m_ctr[s] >= 2);
      tgt  = owns ? m_tgt[s] : 32'h0;
   endfunction

   function automatic void model_update(input int unsigned pc, input int unsigned tgt, input bit tk, input bit jmp);
      int s;
      s = slot_of(pc);
      if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
         if (jmp || tk) begin
            m_ctr[s] = jmp ? 3 : ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1);
            m_tgt[s] = tgt;
         end else begin
            m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
         end
      end else if (tk || jmp) begin
         m_valid[s] = 1;
         m_tag[s]   = tag_of(pc);
         m_tgt[s]   = tgt;
         m_ctr[s]   = jmp ? 3 : 2;
      end
   endfunction

   // Called at posedge+1: drive one cycle, queue the pre-update expectation,
   // then let the edge commit and mirror the update in the model.
   task automatic cycle(input string name, input logic [31:0] pc, input logic upd,
                        input logic [31:0] upc, input logic [31:0] utgt,
                        input logic tk, input logic jmp);
      exp_t e;
      pc_i            = pc;
      update_i        = upd;
      update_pc_i     = upc;
      update_target_i = utgt;
      taken_i         = tk;
      is_jump_i       = jmp;
      e.pc   = pc;
      e.name = name;
      model_lookup(pc, e.hit, e.tgt);
      exp_q.push_back(e);
      chk_req = 1;
      @(posedge clk_i);
      if (upd && rst_ni) model_update(upc, utgt, tk, jmp);
      #1;
   endtask

   task automatic look(input string name, input logic [31:0] pc);
      cycle(name, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic upd(input string name, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic tk, input logic jmp);
      cycle(name, upc, 1'b1, upc, utgt, tk, jmp);
   endtask

   // Monitor: outputs are combinational, so every sampled negedge presents one.
   always @(negedge clk_i) begin
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_underflow: no expectation queued at t=%0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (hit_o !== e.hit) begin
               errors++;
               $display("FAIL %s hit pc=%h: got %b expected %b", e.name, e.pc, hit_o, e.hit);
            end
            checks++;
            if (predicted_pc_o !== e.tgt) begin
               errors++;
               $display("FAIL %s target pc=%h: got %h expected %h", e.name, e.pc, predicted_pc_o, e.tgt);
            end
         end
      end
   end

   initial begin
      rst_ni          = 1'b0;
      pc_i            = 32'h0;
      update_i        = 1'b0;
      update_pc_i     = 32'h0;
      update_target_i = 32'h0;
      taken_i         = 1'b0;
      is_jump_i       = 1'b0;
      model_reset();
      @(posedge clk_i);
      #1;
      look("reset_state", 32'h100);
      rst_ni = 1'b1;

      look("cold_start", 32'h100);
      upd("alloc", 32'h100, 32'h200, 1'b1, 1'b0);
      look("alloc_hit", 32'h100);
      look("alloc_neighbor", 32'h104);

      upd("nt_to_01", 32'h100, 32'h0, 1'b0, 1'b0);
      look("weak_nt", 32'h100);
      for (int k = 0; k < 3; k++) upd("taken_sat", 32'h100, 32'h240, 1'b1, 1'b0);
      look("strong_t", 32'h100);
      upd("nt_to_10", 32'h100, 32'h0, 1'b0, 1'b0);
      look("weak_t", 32'h100);
      for (int k = 0; k < 5; k++) upd("nt_sat", 32'h100, 32'h0, 1'b0, 1'b0);
      look("strong_nt", 32'h100);
      upd("retrain", 32'h100, 32'h200, 1'b1, 1'b0);

      look("alias_miss", 32'h180);
      upd("alias_nt", 32'h180, 32'h300, 1'b0, 1'b0);
      look("alias_keep", 32'h100);
      upd("alias_alloc", 32'h180, 32'h300, 1'b1, 1'b0);
      look("alias_new", 32'h180);
      look("alias_evicted", 32'h100);

      upd("jump_alloc", 32'h400, 32'h800, 1'b0, 1'b1);
      look("jump_hit", 32'h400);
      upd("conflict", 32'h400, 32'h900, 1'b1, 1'b0);
      look("conflict_after", 32'h400);

      // Random traffic over a small PC pool so hits, aliasing and saturation recur.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] lpc, upc, tgt;
         logic        u, tk, jmp;
         lpc = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         upc = ($urandom_range(0, 2) == 0) ? lpc :
               {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         tgt = $urandom;
         u   = ($urandom_range(0, 1) == 1);
         tk  = ($urandom_range(0, 1) == 1);
         jmp = ($urandom_range(0, 7) == 0);
         cycle("random", lpc, u, upc, tgt, tk, jmp);
      end

      // Mid-operation reset between edges, with an update pending at the edge.
      upd("pre_rst_a", 32'h500, 32'h5000, 1'b0, 1'b1);
      upd("pre_rst_b", 32'h544, 32'h5440, 1'b0, 1'b1);
      look("pre_rst_hit", 32'h500);
      begin
         exp_t e;
         pc_i            = 32'h544;
         update_i        = 1'b1;
         update_pc_i     = 32'h600;
         update_target_i = 32'h6000;
         taken_i         = 1'b1;
         is_jump_i       = 1'b1;
         #2;
         rst_ni = 1'b0;
         model_reset();
         e.pc = 32'h544; e.name = "async_reset"; e.hit = 1'b0; e.tgt = 32'h0;
         exp_q.push_back(e);
         @(posedge clk_i);
         #1;
         chk_req = 1'b0;
         rst_ni  = 1'b1;
      end
      look("post_rst_a", 32'h500);
      look("post_rst_b", 32'h544);
      look("post_rst_pending", 32'h600);
      look("post_rst_alias", 32'h180);

      for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge clk_i);
      #1;
      chk_req = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
